// File: rtl/result_bcd_capture.sv
// result_bcd_capture
// Captures the evaluator result on each rising edge of result_valid_in.
// It converts the result to packed BCD with a sequential shift-add-3
// (double-dabble) engine and holds the digits for display.
// Optional feature macro: SEVSEG_EN adds the active-low seven-segment
// outputs hex_n, with leading-zero blanking.

module result_bcd_capture #(
  parameter int DATA_W = 8,
  parameter int NDIG   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   result_in,
  input  logic                result_valid_in,
  output logic [4*NDIG-1:0]   bcd_out,
  output logic                bcd_valid,
  output logic                busy,
  output logic                overrun,
  output logic [7:0]          conv_count
`ifdef SEVSEG_EN
  ,
  output logic [7*NDIG-1:0]   hex_n
`endif
);

  localparam int SHIFT_W = 4*NDIG + DATA_W;
  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam longint unsigned MAX_DEC = pow10(NDIG);
  localparam longint unsigned MAX_BIN = (64'd1 << DATA_W) - 64'd1;

  // NDIG digits must be able to represent the largest DATA_W-bit value
  if (MAX_DEC <= MAX_BIN) begin : g_param_check
    $error("result_bcd_capture: NDIG too small for DATA_W");
  end

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t               state;
  state_t               next_state;
  logic                 valid_d;
  logic                 capture_edge;
  logic                 last_iter;
  logic [CNT_W-1:0]     iter_cnt;
  logic [SHIFT_W-1:0]   shift_q;
  logic [SHIFT_W-1:0]   shift_adj;
  logic [SHIFT_W-1:0]   shift_next;

  assign capture_edge = result_valid_in & ~valid_d;
  assign last_iter    = (state == CONVERT) && (iter_cnt == LAST_ITER);
  assign busy         = (state == CONVERT);

  // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left
  always_comb begin
    shift_adj = shift_q;
    for (int d = 0; d < NDIG; d++) begin
      if (shift_q[DATA_W + 4*d +: 4] >= 4'd5)
        shift_adj[DATA_W + 4*d +: 4] = shift_q[DATA_W + 4*d +: 4] + 4'd3;
    end
    shift_next = {shift_adj[SHIFT_W-2:0], 1'b0};
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: edges while converting never restart the engine
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (capture_edge) next_state = CONVERT;
      CONVERT: if (last_iter)    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: edge detect, shift engine, result hold and status counters
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_d    <= 1'b0;
      iter_cnt   <= '0;
      shift_q    <= '0;
      bcd_out    <= '0;
      bcd_valid  <= 1'b0;
      overrun    <= 1'b0;
      conv_count <= '0;
    end else begin
      valid_d   <= result_valid_in;
      bcd_valid <= 1'b0;
      if (state == IDLE && capture_edge) begin
        shift_q  <= {{(4*NDIG){1'b0}}, result_in};
        iter_cnt <= '0;
      end else if (state == CONVERT) begin
        shift_q  <= shift_next;
        iter_cnt <= iter_cnt + CNT_W'(1);
        if (last_iter) begin
          bcd_out    <= shift_next[SHIFT_W-1 -: 4*NDIG];
          bcd_valid  <= 1'b1;
          conv_count <= conv_count + 8'd1;
        end
      end
      if (state == CONVERT && capture_edge) overrun <= 1'b1;
    end
  end

`ifdef SEVSEG_EN
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // Segment decode with leading-zero blanking, scanning from the top digit
  always_comb begin
    logic       lead;
    logic [3:0] digit;
    hex_n = '1;
    lead  = 1'b1;
    digit = '0;
    for (int d = NDIG-1; d >= 0; d--) begin
      digit = bcd_out[4*d +: 4];
      if (digit != 4'd0) lead = 1'b0;
      if (lead && d != 0) hex_n[7*d +: 7] = 7'h7F;
      else                hex_n[7*d +: 7] = seg_decode(digit);
    end
  end
`endif

endmodule

// File: tb/tb_result_bcd_capture.sv
// tb_result_bcd_capture
// Directed bench for result_bcd_capture (defaults DATA_W=8, NDIG=3).
// Build with SEVSEG_EN defined to also check the seven-segment outputs.

module tb_result_bcd_capture;

  logic        clk;
  logic        reset;
  logic [7:0]  result_in;
  logic        result_valid_in;
  logic [11:0] bcd_out;
  logic        bcd_valid;
  logic        busy;
  logic        overrun;
  logic [7:0]  conv_count;
`ifdef SEVSEG_EN
  logic [20:0] hex_n;
`endif

  int compared   = 0;
  int mismatched = 0;

  result_bcd_capture #(.DATA_W(8), .NDIG(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .result_in       (result_in),
    .result_valid_in (result_valid_in),
    .bcd_out         (bcd_out),
    .bcd_valid       (bcd_valid),
    .busy            (busy),
    .overrun         (overrun),
`ifdef SEVSEG_EN
    .hex_n           (hex_n),
`endif
    .conv_count      (conv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Raise result_valid_in so the next edge is E0; return just after E0
  task automatic applyStimulus(input logic [7:0] value, input bit keep_high);
    result_in       = value;
    result_valid_in = 1'b1;
    step();
    if (!keep_high) result_valid_in = 1'b0;
    result_in = ~value;
  endtask

  // Wait (bounded) for the bcd_valid pulse and check how many edges it took
  task automatic waitDone(input string tag, input int expect_n);
    int n;
    n = 0;
    while (n < 30) begin
      step();
      n++;
      if (bcd_valid) break;
    end
    checkOutput({tag, "_valid_seen"}, 32'(bcd_valid), 32'd1);
    checkOutput({tag, "_latency"}, 32'(n), 32'(expect_n));
  endtask

  task automatic doReset();
    reset           = 1'b1;
    result_valid_in = 1'b0;
    result_in       = '0;
    step(); step(); step();
    reset = 1'b0;
  endtask

  initial begin
    bit seen;

    // Reset state
    doReset();
    checkOutput("rst_bcd_out",    32'(bcd_out),    32'h000);
    checkOutput("rst_bcd_valid",  32'(bcd_valid),  32'd0);
    checkOutput("rst_busy",       32'(busy),       32'd0);
    checkOutput("rst_overrun",    32'(overrun),    32'd0);
    checkOutput("rst_conv_count", 32'(conv_count), 32'd0);
    step();

    // 255: busy from E0, no partial results, valid after E8
    applyStimulus(8'd255, 1'b0);
    checkOutput("c255_busy_e0", 32'(busy), 32'd1);
    step(); step(); step();
    checkOutput("c255_busy_e3", 32'(busy), 32'd1);
    checkOutput("c255_hold_e3", 32'(bcd_out), 32'h000);
    waitDone("c255", 5);
    checkOutput("c255_bcd",   32'(bcd_out),    32'h255);
    checkOutput("c255_count", 32'(conv_count), 32'd1);
    checkOutput("c255_busy_done", 32'(busy),   32'd0);
    step();
    checkOutput("c255_pulse_len", 32'(bcd_valid), 32'd0);

    // 0 with valid held high: only one capture
    applyStimulus(8'd0, 1'b1);
    waitDone("c0", 8);
    checkOutput("c0_bcd",   32'(bcd_out),    32'h000);
    checkOutput("c0_count", 32'(conv_count), 32'd2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bcd_valid || busy) seen = 1'b1;
    end
    checkOutput("c0_level_no_recapture", 32'(seen), 32'd0);
    checkOutput("c0_count_hold", 32'(conv_count), 32'd2);
    result_valid_in = 1'b0;
    step();

    // 100 with a second edge at E3 carrying 42
    applyStimulus(8'd100, 1'b1);
    step();
    result_valid_in = 1'b0;
    step();
    result_valid_in = 1'b1;
    result_in       = 8'd42;
    step();
    checkOutput("c100_overrun", 32'(overrun), 32'd1);
    checkOutput("c100_busy_e3", 32'(busy),    32'd1);
    waitDone("c100", 5);
    checkOutput("c100_bcd",   32'(bcd_out),    32'h100);
    checkOutput("c100_count", 32'(conv_count), 32'd3);
    step();
    checkOutput("c100_no_restart", 32'(busy), 32'd0);
    result_valid_in = 1'b0;
    step(); step();
    checkOutput("c100_count_hold", 32'(conv_count), 32'd3);

    // 7 and 205 (segment checks when enabled)
    applyStimulus(8'd7, 1'b0);
    waitDone("c7", 8);
    checkOutput("c7_bcd", 32'(bcd_out), 32'h007);
`ifdef SEVSEG_EN
    checkOutput("c7_hex2", 32'(hex_n[20:14]), 32'h7F);
    checkOutput("c7_hex1", 32'(hex_n[13:7]),  32'h7F);
    checkOutput("c7_hex0", 32'(hex_n[6:0]),   32'(7'b1111000));
`endif
    step();
    applyStimulus(8'd205, 1'b0);
    waitDone("c205", 8);
    checkOutput("c205_bcd",   32'(bcd_out),    32'h205);
    checkOutput("c205_count", 32'(conv_count), 32'd5);
`ifdef SEVSEG_EN
    checkOutput("c205_hex2", 32'(hex_n[20:14]), 32'(7'b0100100));
    checkOutput("c205_hex1", 32'(hex_n[13:7]),  32'(7'b1000000));
    checkOutput("c205_hex0", 32'(hex_n[6:0]),   32'(7'b0010010));
`endif
    step();

    // 199 abandoned by reset at E4
    applyStimulus(8'd199, 1'b0);
    step(); step(); step();
    reset = 1'b1;
    step();
    checkOutput("mid_rst_bcd",     32'(bcd_out),    32'h000);
    checkOutput("mid_rst_valid",   32'(bcd_valid),  32'd0);
    checkOutput("mid_rst_busy",    32'(busy),       32'd0);
    checkOutput("mid_rst_overrun", 32'(overrun),    32'd0);
    checkOutput("mid_rst_count",   32'(conv_count), 32'd0);
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bcd_valid) seen = 1'b1;
    end
    checkOutput("mid_rst_no_pulse", 32'(seen), 32'd0);
    applyStimulus(8'd58, 1'b0);
    waitDone("c58", 8);
    checkOutput("c58_bcd",   32'(bcd_out),    32'h058);
    checkOutput("c58_count", 32'(conv_count), 32'd1);
    step();

    // 256 captures spaced 12 cycles: counter wraps to 0, no overrun
    doReset();
    step();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(8'(i), 1'b0);
      repeat (11) step();
      if (i == 254) checkOutput("wrap_count_255", 32'(conv_count), 32'd255);
    end
    checkOutput("wrap_count_0",  32'(conv_count), 32'd0);
    checkOutput("wrap_overrun",  32'(overrun),    32'd0);
    checkOutput("wrap_last_bcd", 32'(bcd_out),    32'h255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
